cyclic_shift_reg_pp: RTL
========================

Name: cyclic_shift_reg_pp

Overview:
Double-buffered (ping-pong) successor to the single-bank cyclic shift register, with AXI-stream-style handshakes on both sides. Wide write beats fill one bank while the other bank is read out narrow-word by narrow-word. Each bank is read cyclically over a programmable length for a programmable number of passes, then released for refill. It sits between the weight/pixel DMA stream and the PE array, so loading the next tile overlaps reuse of the current one.

Parameters:
R_DEPTH, 24, words per bank (narrow side)
R_DATA_WIDTH, 16, narrow (read) word width
W_DATA_WIDTH, 192, write beat width; must be an integer multiple of R_DATA_WIDTH
REPEAT_WIDTH, 8, width of the pass-count config
Derived: RATIO=W_DATA_WIDTH/R_DATA_WIDTH; W_DEPTH=R_DEPTH/RATIO; W_ADDR_WIDTH=$clog2(W_DEPTH); R_ADDR_WIDTH=$clog2(R_DEPTH)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
clken  in  1  global clock enable; gates every state update and handshake
s_valid  in  1  write beat valid
s_ready  out  1  write beat accepted when s_valid&&s_ready
s_data  in  W_DATA_WIDTH  write beat; element i = s_data[(i+1)*R_DATA_WIDTH-1 : i*R_DATA_WIDTH]
w_addr_max  in  W_ADDR_WIDTH  last beat index of a fill; sampled on the first beat of each fill
r_addr_max  in  R_ADDR_WIDTH  last element of a pass; sampled on the first beat of each fill
r_repeat_max  in  REPEAT_WIDTH  passes minus one; sampled on the first beat of each fill
m_valid  out  1  read word valid
m_ready  in  1  read word consumed when m_valid&&m_ready
m_data  out  R_DATA_WIDTH  current read word
m_pass_last  out  1  last word of a pass
m_last  out  1  last word of the final pass of a bank

Behaviour:
- Reset (async, resetn=0): both banks EMPTY; write pointer=read pointer=bank 0. All counters are 0. Outputs: m_valid=0, m_data=0, m_pass_last=0, m_last=0. s_ready=1 from the first cycle after reset.
- Per-bank state: EMPTY -> FILLING (first accepted beat) -> FULL (accepted beat with w_addr==stored w_addr_max) -> EMPTY (final read handshake).
  - A one-beat fill (w_addr_max=0) goes EMPTY->FULL directly.
- Write side:
  - s_ready = clken && bank[wptr]!=FULL.
  - Beat w writes elements w*RATIO .. w*RATIO+RATIO-1 of bank[wptr].
  - On commit (FULL), wptr toggles and w_addr clears.
- Read side:
  - m_valid = clken && bank[rptr]==FULL.
  - m_data = element 0 of bank[rptr]; registers are muxed directly, with no output pipeline.
  - Each read handshake rotates bank[rptr] by one over elements 0..r_addr_max only: element k takes k+1, and element r_addr_max takes element 0.
  - After r_addr_max+1 handshakes the bank contents are restored, so every pass emits an identical sequence.
  - Elements above r_addr_max are held and never output.
- Counters:
  - Pass element counter: m_pass_last = m_valid && (elem_cnt==r_addr_max).
  - Pass counter: m_last = m_pass_last && (pass_cnt==r_repeat_max).
  - The m_last handshake sets the bank to EMPTY and toggles rptr.
- Latency:
  - Commit edge to m_valid high: 1 cycle (next cycle).
  - Release edge to s_ready high for that bank: 1 cycle.
  - There is no combinational path m_ready->s_ready or s_valid->m_valid.
- Simultaneous events:
  - Commit of one bank and release of the other on the same edge both take effect.
  - If wptr==rptr with the bank FULL, the writer stalls (s_ready=0) until release.
- Backpressure: while m_valid && !m_ready, m_data, m_pass_last and m_last hold stable.
- clken=0: no register changes, handshakes are masked, and contents and counters are frozen.
- Reset mid-operation: all in-flight data is discarded, with no partial output; the next fill starts in bank 0.
- Config: w_addr_max, r_addr_max and r_repeat_max are stored per bank at the first beat. Changing the inputs mid-fill has no effect on that bank.
- Illegal config: w_addr_max>=W_DEPTH or r_addr_max>=R_DEPTH is undefined; a simulation assertion must flag it.

Decomposition:
- Shared package: bank_state_t enum {EMPTY, FILLING, FULL}; a per-bank config struct {w_addr_max, r_addr_max, r_repeat_max}.
- Sub-module cyclic_shift_bank: one bank's register array with load (beat index and data) and rotate (r_addr_max) controls.
- The top instantiates two banks plus the pointer/counter FSM.

Test Plan (R_DEPTH=8, R_DATA_WIDTH=8, W_DATA_WIDTH=32, RATIO=4, W_DEPTH=2):
1. Beats 0x03020100, 0x07060504 with w_addr_max=1, r_addr_max=7, r_repeat_max=1, m_ready=1 -> m_data 00..07, 00..07. m_pass_last on beats 8 and 16; m_last on beat 16 only. m_valid drops the cycle after.
2. Same fill with r_addr_max=4, r_repeat_max=2 -> 00,01,02,03,04 three times. Elements 05..07 are never output. m_last on the 15th word.
3. Ping-pong: the bank-1 fill (0x13121110, 0x17161514) is accepted while bank 0 reads, with s_ready=1 throughout. A third fill sees s_ready=0 until bank 0's m_last handshake, then s_ready=1 the next cycle. Bank-1 output starts 10 with no gap cycle.
4. Backpressure: m_ready pattern 1,0,0,1,0,1,... -> the output sequence equals scenario 1. m_data and flags are stable on every stall cycle.
5. clken=0 for 3 cycles mid-pass (after word 03) -> m_valid=0 and s_ready=0. On resume, the next word is 04 with counters unchanged.
6. resetn pulsed low after word 05 -> m_valid=0 immediately; s_ready=1 after release. A new fill 0xA3A2A1A0, 0xA7A6A5A4 reads A0..A7 with no stale data.

Source files
------------

// File: rtl/cyclic_shift_reg_pp_pkg.sv
// Shared types for the ping-pong cyclic shift register: bank lifecycle state and
// the per-bank configuration captured on the first beat of each fill.
package cyclic_shift_reg_pp_pkg;

  localparam int CFG_W = 16;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } bank_state_t;

  typedef struct packed {
    logic [CFG_W-1:0] w_addr_max;
    logic [CFG_W-1:0] r_addr_max;
    logic [CFG_W-1:0] r_repeat_max;
  } bank_cfg_t;

endpackage

// File: rtl/cyclic_shift_reg_pp_bank.sv
// One bank: wide-beat load into a word array, rotate-by-one over words 0..rot_max.
// Word 0 is presented combinationally; load and rotate never target the same bank together.
module cyclic_shift_bank
  import cyclic_shift_reg_pp_pkg::*;
#(
  parameter int R_DEPTH      = 24,
  parameter int R_DATA_WIDTH = 16,
  parameter int RATIO        = 12,
  parameter int W_DEPTH      = 2,
  parameter int W_AW         = 1,
  parameter int R_AW         = 5
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          load_i,
  input  logic [W_AW-1:0]               load_idx_i,
  input  logic [RATIO*R_DATA_WIDTH-1:0] load_dat_i,
  input  logic                          rot_i,
  input  logic [R_AW-1:0]               rot_max_i,
  output logic [R_DATA_WIDTH-1:0]       head_o
);

  logic [R_DATA_WIDTH-1:0] mem_q [R_DEPTH];
  logic [R_DATA_WIDTH-1:0] mem_d [R_DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (load_i) begin
      for (int w = 0; w < W_DEPTH; w++) begin
        if (load_idx_i == W_AW'(w)) begin
          for (int r = 0; r < RATIO; r++) begin
            mem_d[w*RATIO+r] = load_dat_i[r*R_DATA_WIDTH +: R_DATA_WIDTH];
          end
        end
      end
    end else if (rot_i) begin
      // Words above rot_max keep their value; the modulo only keeps the index legal.
      for (int k = 0; k < R_DEPTH; k++) begin
        if (R_AW'(k) < rot_max_i) begin
          mem_d[k] = mem_q[(k+1) % R_DEPTH];
        end else if (R_AW'(k) == rot_max_i) begin
          mem_d[k] = mem_q[0];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < R_DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign head_o = mem_q[0];

endmodule

// File: rtl/cyclic_shift_reg_pp.sv
// Ping-pong cyclic shift register: one bank fills from wide beats while the other is replayed
// narrow word by word; commit/release reach the opposite side one cycle later, no comb paths across.
module cyclic_shift_reg_pp
  import cyclic_shift_reg_pp_pkg::*;
#(
  parameter int R_DEPTH      = 24,
  parameter int R_DATA_WIDTH = 16,
  parameter int W_DATA_WIDTH = 192,
  parameter int REPEAT_WIDTH = 8,
  parameter int RATIO        = W_DATA_WIDTH / R_DATA_WIDTH,
  parameter int W_DEPTH      = R_DEPTH / RATIO,
  parameter int W_ADDR_WIDTH = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1,
  parameter int R_ADDR_WIDTH = (R_DEPTH > 1) ? $clog2(R_DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    clken,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [W_DATA_WIDTH-1:0] s_data,
  input  logic [W_ADDR_WIDTH-1:0] w_addr_max,
  input  logic [R_ADDR_WIDTH-1:0] r_addr_max,
  input  logic [REPEAT_WIDTH-1:0] r_repeat_max,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [R_DATA_WIDTH-1:0] m_data,
  output logic                    m_pass_last,
  output logic                    m_last
);

  bank_state_t st_q [2];
  bank_state_t st_d [2];
  bank_cfg_t   cfg_q [2];
  bank_cfg_t   cfg_d [2];
  logic        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [W_ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [R_ADDR_WIDTH-1:0] elem_cnt_q, elem_cnt_d;
  logic [REPEAT_WIDTH-1:0] pass_cnt_q, pass_cnt_d;

  logic             wr_first, wr_fire, rd_fire, commit;
  logic [CFG_W-1:0] wmax_eff;
  logic [R_DATA_WIDTH-1:0] head [2];

  assign s_ready  = clken && (st_q[wptr_q] != FULL);
  assign m_valid  = clken && (st_q[rptr_q] == FULL);
  assign wr_fire  = s_valid && s_ready;
  assign rd_fire  = m_valid && m_ready;
  assign wr_first = (st_q[wptr_q] == EMPTY);

  // The first beat of a fill must see its own w_addr_max, before it is stored.
  assign wmax_eff = wr_first ? CFG_W'(w_addr_max) : cfg_q[wptr_q].w_addr_max;
  assign commit   = wr_fire && (CFG_W'(w_addr_q) == wmax_eff);

  assign m_pass_last = m_valid && (CFG_W'(elem_cnt_q) == cfg_q[rptr_q].r_addr_max);
  assign m_last      = m_pass_last && (CFG_W'(pass_cnt_q) == cfg_q[rptr_q].r_repeat_max);
  assign m_data      = head[rptr_q];

  always_comb begin
    st_d       = st_q;
    cfg_d      = cfg_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    w_addr_d   = w_addr_q;
    elem_cnt_d = elem_cnt_q;
    pass_cnt_d = pass_cnt_q;

    // Write and read always address different banks (not-FULL vs FULL), so both may apply.
    if (wr_fire) begin
      if (wr_first) begin
        cfg_d[wptr_q].w_addr_max   = CFG_W'(w_addr_max);
        cfg_d[wptr_q].r_addr_max   = CFG_W'(r_addr_max);
        cfg_d[wptr_q].r_repeat_max = CFG_W'(r_repeat_max);
      end
      if (commit) begin
        st_d[wptr_q] = FULL;
        wptr_d       = ~wptr_q;
        w_addr_d     = '0;
      end else begin
        st_d[wptr_q] = FILLING;
        w_addr_d     = w_addr_q + W_ADDR_WIDTH'(1);
      end
    end

    if (rd_fire) begin
      if (m_pass_last) begin
        elem_cnt_d = '0;
        if (m_last) begin
          pass_cnt_d   = '0;
          st_d[rptr_q] = EMPTY;
          rptr_d       = ~rptr_q;
        end else begin
          pass_cnt_d = pass_cnt_q + REPEAT_WIDTH'(1);
        end
      end else begin
        elem_cnt_d = elem_cnt_q + R_ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q[0]    <= EMPTY;
      st_q[1]    <= EMPTY;
      cfg_q[0]   <= '0;
      cfg_q[1]   <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      w_addr_q   <= '0;
      elem_cnt_q <= '0;
      pass_cnt_q <= '0;
    end else begin
      st_q       <= st_d;
      cfg_q      <= cfg_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      w_addr_q   <= w_addr_d;
      elem_cnt_q <= elem_cnt_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    cyclic_shift_bank #(
      .R_DEPTH     (R_DEPTH),
      .R_DATA_WIDTH(R_DATA_WIDTH),
      .RATIO       (RATIO),
      .W_DEPTH     (W_DEPTH),
      .W_AW        (W_ADDR_WIDTH),
      .R_AW        (R_ADDR_WIDTH)
    ) u_bank (
      .clk_i     (clk),
      .rst_ni    (resetn),
      .load_i    (wr_fire && (wptr_q == 1'(b))),
      .load_idx_i(w_addr_q),
      .load_dat_i(s_data),
      .rot_i     (rd_fire && (rptr_q == 1'(b))),
      .rot_max_i (cfg_q[b].r_addr_max[R_ADDR_WIDTH-1:0]),
      .head_o    (head[b])
    );
  end

  localparam logic [CFG_W-1:0] W_LIM = CFG_W'(W_DEPTH);
  localparam logic [CFG_W-1:0] R_LIM = CFG_W'(R_DEPTH);

  a_cfg_legal : assert property (@(posedge clk) disable iff (!resetn)
    (wr_fire && wr_first) |-> ((CFG_W'(w_addr_max) < W_LIM) && (CFG_W'(r_addr_max) < R_LIM)));

endmodule
